// File: rtl/dmi_pkg.sv
// Shared types and constants for the core-domain DMI request controller.
package dmi_pkg;

  localparam int unsigned DMI_AW    = 7;
  localparam int unsigned DMI_DW    = 32;
  localparam int unsigned DMI_TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RSP   = 2'd2,
    DRAIN = 2'd3
  } dmi_state_e;

  localparam logic [1:0] DMI_OK   = 2'd0;
  localparam logic [1:0] DMI_FAIL = 2'd2;
  localparam logic [1:0] DMI_BUSY = 2'd3;

endpackage

// File: rtl/dmi_core_req_ctrl_if.sv
// Request/response bus between the DMI request controller and the debug module.
interface dmi_core_req_ctrl_if
  import dmi_pkg::*;
#(
  parameter int unsigned AW = DMI_AW,
  parameter int unsigned DW = DMI_DW
) ();

  logic          dmi_req_valid;
  logic          dmi_req_ready;
  logic          dmi_req_wr;
  logic [AW-1:0] dmi_req_addr;
  logic [DW-1:0] dmi_req_wdata;
  logic          dmi_rsp_valid;
  logic [DW-1:0] dmi_rsp_data;
  logic          dmi_rsp_err;

  modport master (
    output dmi_req_valid, dmi_req_wr, dmi_req_addr, dmi_req_wdata,
    input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_err
  );

  modport slave (
    input  dmi_req_valid, dmi_req_wr, dmi_req_addr, dmi_req_wdata,
    output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_err
  );

endinterface

// File: rtl/dmi_core_req_ctrl.sv
// Core-domain DMI request controller: issues one request per accepted access,
// waits for the response with a timeout, and reports completion as a toggle.
module dmi_core_req_ctrl
  import dmi_pkg::*;
#(
  parameter int unsigned AW    = DMI_AW,
  parameter int unsigned DW    = DMI_DW,
  parameter int unsigned TMO_W = DMI_TMO_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_en,
  input  logic                reg_wr_en,
  input  logic [AW-1:0]       reg_addr,
  input  logic [DW-1:0]       reg_wdata,
  input  logic                dmi_clr,
  dmi_core_req_ctrl_if.master dmi,
  output logic [DW-1:0]       rdata_hold,
  output logic [1:0]          rsp_status,
  output logic                done_tgl,
  output logic                busy
);

  dmi_state_e       state;
  logic [TMO_W-1:0] cnt;
  logic [TMO_W-1:0] cnt_inc;
  logic             accept;
  logic             overrun;
  logic             rsp_hit;
  logic             tmo_hit;
  logic             fail_set;

  // Event decode; a response in the saturating cycle beats the timeout.
  always_comb begin
    cnt_inc  = cnt + TMO_W'(1);
    overrun  = reg_en && (state != IDLE);
    accept   = reg_en && (state == IDLE) && ((rsp_status == DMI_OK) || dmi_clr);
    rsp_hit  = (state == RSP) && dmi.dmi_rsp_valid;
    tmo_hit  = (state == RSP) && !dmi.dmi_rsp_valid && (cnt_inc == '1);
    fail_set = (rsp_hit && dmi.dmi_rsp_err) || tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      dmi.dmi_req_valid <= 1'b0;
      dmi.dmi_req_wr    <= 1'b0;
      dmi.dmi_req_addr  <= '0;
      dmi.dmi_req_wdata <= '0;
      rdata_hold        <= '0;
      rsp_status        <= DMI_OK;
      done_tgl          <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dmi.dmi_req_wr    <= reg_wr_en;
            dmi.dmi_req_addr  <= reg_addr;
            dmi.dmi_req_wdata <= reg_wdata;
            dmi.dmi_req_valid <= 1'b1;
            busy              <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (dmi.dmi_req_valid && dmi.dmi_req_ready) begin
            dmi.dmi_req_valid <= 1'b0;
            cnt               <= '0;
            state             <= RSP;
          end
        end
        RSP: begin
          if (rsp_hit) begin
            if (!dmi.dmi_req_wr) begin
              rdata_hold <= dmi.dmi_rsp_data;
            end
            done_tgl <= ~done_tgl;
            cnt      <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (tmo_hit) begin
            done_tgl <= ~done_tgl;
            cnt      <= '0;
            state    <= DRAIN;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DRAIN: begin
          // The late response is swallowed so the debug module sees a closed handshake.
          if (dmi.dmi_rsp_valid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Busy is the stronger indication and is never downgraded to failed.
      if (overrun) begin
        rsp_status <= DMI_BUSY;
      end else if (fail_set) begin
        rsp_status <= (rsp_status == DMI_BUSY) ? DMI_BUSY : DMI_FAIL;
      end else if (dmi_clr) begin
        rsp_status <= DMI_OK;
      end
    end
  end

  // Responses are only legal while a request is outstanding or being drained.
  rsp_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    dmi.dmi_rsp_valid |-> ((state == RSP) || (state == DRAIN)));

endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// Bench for dmi_core_req_ctrl: vector table, directed corner cases, random vs. model.
module tb_dmi_core_req_ctrl;

  localparam int unsigned AW      = 7;
  localparam int unsigned DW      = 32;
  localparam int unsigned TMO_W   = 8;
  localparam int          TMO_MAX = 255;
  localparam int          NV      = 26;
  localparam int          NRAND   = 4000;

  logic          clk;
  logic          rst_n;
  logic          reg_en;
  logic          reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          dmi_clr;
  logic [DW-1:0] rdata_hold;
  logic [1:0]    rsp_status;
  logic          done_tgl;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  dmi_core_req_ctrl_if #(.AW(AW), .DW(DW)) dmi ();

  dmi_core_req_ctrl #(.AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_en     (reg_en),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .dmi_clr    (dmi_clr),
    .dmi        (dmi),
    .rdata_hold (rdata_hold),
    .rsp_status (rsp_status),
    .done_tgl   (done_tgl),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1);
  end

  typedef struct {
    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          clr;
    logic          rdy;
    logic          rv;
    logic [DW-1:0] rdata;
    logic          rerr;
    logic          e_valid;
    logic          e_busy;
    logic [1:0]    e_st;
    logic          e_done;
    logic [DW-1:0] e_rdata;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t tab [NV];

  function automatic vec_t mk(input logic en, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic clr, input logic rdy,
                              input logic rv, input logic [DW-1:0] rd, input logic rerr,
                              input logic ev, input logic eb, input logic [1:0] est,
                              input logic ed, input logic [DW-1:0] erd, input logic [AW-1:0] ea);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.wdata = wd; v.clr = clr; v.rdy = rdy;
    v.rv = rv; v.rdata = rd; v.rerr = rerr; v.e_valid = ev; v.e_busy = eb;
    v.e_st = est; v.e_done = ed; v.e_rdata = erd; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reg_en             = 1'b0;
    reg_wr_en          = 1'b0;
    reg_addr           = '0;
    reg_wdata          = '0;
    dmi_clr            = 1'b0;
    dmi.dmi_req_ready  = 1'b0;
    dmi.dmi_rsp_valid  = 1'b0;
    dmi.dmi_rsp_data   = '0;
    dmi.dmi_rsp_err    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string nm, input logic ev, input logic eb, input logic [1:0] est,
                          input logic ed, input logic [DW-1:0] erd);
    chk({nm, ".valid"}, 32'(dmi.dmi_req_valid), 32'(ev));
    chk({nm, ".busy"},  32'(busy),              32'(eb));
    chk({nm, ".status"}, 32'(rsp_status),       32'(est));
    chk({nm, ".done"},  32'(done_tgl),          32'(ed));
    chk({nm, ".rdata"}, 32'(rdata_hold),        32'(erd));
  endtask

  // Reference model state for the random phase (transaction view of the controller)
  bit            m_req, m_wait, m_drain;
  int            m_age;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    m_st;
  logic          m_done;
  int            resp_cd;

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TMO_MAX - 1;
    if (r == 1) return TMO_MAX + int'($urandom_range(0, 8));
    return int'($urandom_range(0, 6));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Vector table: read, overrun, clear, error, clear+access, clear vs. set
    tab[0]  = mk(1'b1, 1'b0, 7'h11, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        7'h11);
    tab[1]  = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        7'h00);
    tab[2]  = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        7'h00);
    tab[3]  = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        7'h00);
    tab[4]  = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 7'h00);
    tab[5]  = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 7'h00);
    tab[6]  = mk(1'b1, 1'b0, 7'h22, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hDEADBEEF, 7'h22);
    tab[7]  = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'hDEADBEEF, 7'h00);
    tab[8]  = mk(1'b1, 1'b0, 7'h33, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 32'hDEADBEEF, 7'h00);
    tab[9]  = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h12345678, 7'h00);
    tab[10] = mk(1'b1, 1'b0, 7'h44, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h12345678, 7'h00);
    tab[11] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h12345678, 7'h00);
    tab[12] = mk(1'b1, 1'b0, 7'h05, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h12345678, 7'h05);
    tab[13] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h12345678, 7'h00);
    tab[14] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D, 7'h00);
    tab[15] = mk(1'b1, 1'b0, 7'h7F, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hCAFEF00D, 7'h7F);
    tab[16] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'hCAFEF00D, 7'h00);
    tab[17] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'hA5A5A5A5, 7'h00);
    tab[18] = mk(1'b1, 1'b0, 7'h01, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'hA5A5A5A5, 7'h00);
    tab[19] = mk(1'b1, 1'b1, 7'h3C, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'hA5A5A5A5, 7'h3C);
    tab[20] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'hA5A5A5A5, 7'h00);
    tab[21] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hA5A5A5A5, 7'h00);
    tab[22] = mk(1'b1, 1'b0, 7'h02, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hA5A5A5A5, 7'h02);
    tab[23] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'hA5A5A5A5, 7'h00);
    tab[24] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b1, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h22222222, 7'h00);
    tab[25] = mk(1'b0, 1'b0, 7'h00, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h22222222, 7'h00);

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      reg_en            = tab[i].en;
      reg_wr_en         = tab[i].wr;
      reg_addr          = tab[i].addr;
      reg_wdata         = tab[i].wdata;
      dmi_clr           = tab[i].clr;
      dmi.dmi_req_ready = tab[i].rdy;
      dmi.dmi_rsp_valid = tab[i].rv;
      dmi.dmi_rsp_data  = tab[i].rdata;
      dmi.dmi_rsp_err   = tab[i].rerr;
      tick();
      chk_outs($sformatf("vec%0d", i), tab[i].e_valid, tab[i].e_busy, tab[i].e_st,
               tab[i].e_done, tab[i].e_rdata);
      if (tab[i].e_valid) chk($sformatf("vec%0d.addr", i), 32'(dmi.dmi_req_addr), 32'(tab[i].e_addr));
    end
    idle_inputs();

    // Write with 5 cycles of backpressure: request fields hold until the handshake
    reg_en = 1'b1; reg_wr_en = 1'b1; reg_addr = 7'h10; reg_wdata = 32'h1;
    tick();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d.valid", i), 32'(dmi.dmi_req_valid), 32'h1);
      chk($sformatf("bp%0d.wr", i),    32'(dmi.dmi_req_wr),    32'h1);
      chk($sformatf("bp%0d.addr", i),  32'(dmi.dmi_req_addr),  32'h10);
      chk($sformatf("bp%0d.wdata", i), 32'(dmi.dmi_req_wdata), 32'h1);
      dmi.dmi_req_ready = (i == 5);
      tick();
    end
    dmi.dmi_req_ready = 1'b0;
    chk("bp.valid_drop", 32'(dmi.dmi_req_valid), 32'h0);
    chk("bp.busy_rsp",   32'(busy),              32'h1);
    dmi.dmi_rsp_valid = 1'b1; dmi.dmi_rsp_data = 32'h99999999;
    tick();
    idle_inputs();
    chk_outs("bp.done", 1'b0, 1'b0, 2'd0, 1'b1, 32'h22222222);
    tick();
    chk("bp.single_toggle", 32'(done_tgl), 32'h1);

    // Timeout after 255 response cycles, then a drained late response
    reg_en = 1'b1; reg_addr = 7'h11;
    tick();
    idle_inputs();
    dmi.dmi_req_ready = 1'b1;
    tick();
    dmi.dmi_req_ready = 1'b0;
    repeat (TMO_MAX - 1) tick();
    chk_outs("tmo.before", 1'b0, 1'b1, 2'd0, 1'b1, 32'h22222222);
    tick();
    chk_outs("tmo.fire", 1'b0, 1'b1, 2'd2, 1'b0, 32'h22222222);
    repeat (3) tick();
    chk_outs("tmo.drain", 1'b0, 1'b1, 2'd2, 1'b0, 32'h22222222);
    dmi.dmi_rsp_valid = 1'b1; dmi.dmi_rsp_data = 32'h55;
    tick();
    idle_inputs();
    chk_outs("tmo.late_rsp", 1'b0, 1'b0, 2'd2, 1'b0, 32'h22222222);
    reg_en = 1'b1; reg_addr = 7'h11;
    tick();
    idle_inputs();
    chk_outs("tmo.ignored", 1'b0, 1'b0, 2'd2, 1'b0, 32'h22222222);
    dmi_clr = 1'b1;
    tick();
    idle_inputs();
    chk("tmo.clr", 32'(rsp_status), 32'h0);

    // Async reset in the middle of a request cycle
    reg_en = 1'b1; reg_addr = 7'h11;
    tick();
    tick();
    idle_inputs();
    chk("ar.valid_pre",  32'(dmi.dmi_req_valid), 32'h1);
    chk("ar.status_pre", 32'(rsp_status),        32'h3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("ar.async", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reg_en = 1'b1; reg_addr = 7'h15;
    tick();
    idle_inputs();
    chk("ar.rd_valid", 32'(dmi.dmi_req_valid), 32'h1);
    chk("ar.rd_addr",  32'(dmi.dmi_req_addr),  32'h15);
    dmi.dmi_req_ready = 1'b1;
    tick();
    idle_inputs();
    dmi.dmi_rsp_valid = 1'b1; dmi.dmi_rsp_data = 32'h0BADF00D;
    tick();
    idle_inputs();
    chk_outs("ar.rd_done", 1'b0, 1'b0, 2'd0, 1'b1, 32'h0BADF00D);

    // Random traffic against the transaction model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_req = 0; m_wait = 0; m_drain = 0; m_age = 0;
    m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_st = 2'd0; m_done = 1'b0;
    resp_cd = 0;
    for (int c = 0; c < NRAND; c++) begin
      bit fire, pend, busy_pre, fail, hs;
      reg_en            = ($urandom_range(0, 5) == 0);
      reg_wr_en         = 1'($urandom);
      reg_addr          = AW'($urandom);
      reg_wdata         = $urandom;
      dmi_clr           = ($urandom_range(0, 9) == 0);
      dmi.dmi_req_ready = ($urandom_range(0, 2) == 0);
      pend              = m_wait || m_drain;
      fire              = pend && (resp_cd == 0);
      dmi.dmi_rsp_valid = fire;
      dmi.dmi_rsp_data  = $urandom;
      dmi.dmi_rsp_err   = ($urandom_range(0, 4) == 0);
      @(posedge clk);
      busy_pre = m_req || m_wait || m_drain;
      fail = 0;
      hs   = 0;
      if (m_req) begin
        if (dmi.dmi_req_ready) begin
          m_req = 0; m_wait = 1; m_age = 0; hs = 1;
        end
      end else if (m_wait) begin
        m_age++;
        if (fire) begin
          if (!m_wr) m_rdata = dmi.dmi_rsp_data;
          if (dmi.dmi_rsp_err) fail = 1;
          m_done = ~m_done;
          m_wait = 0;
        end else if (m_age == TMO_MAX) begin
          fail = 1;
          m_done = ~m_done;
          m_wait = 0;
          m_drain = 1;
        end
      end else if (m_drain) begin
        if (fire) m_drain = 0;
      end else if (reg_en && (m_st == 2'd0 || dmi_clr)) begin
        m_wr = reg_wr_en; m_addr = reg_addr; m_wdata = reg_wdata; m_req = 1;
      end
      if (reg_en && busy_pre)  m_st = 2'd3;
      else if (fail)           m_st = (m_st == 2'd3) ? 2'd3 : 2'd2;
      else if (dmi_clr)        m_st = 2'd0;
      if (hs)                  resp_cd = pick_delay();
      else if (pend && !fire)  resp_cd--;
      #1;
      chk_outs($sformatf("rnd%0d", c), m_req, m_req || m_wait || m_drain, m_st, m_done, m_rdata);
      if (m_req) begin
        chk($sformatf("rnd%0d.wr", c),    32'(dmi.dmi_req_wr),    32'(m_wr));
        chk($sformatf("rnd%0d.addr", c),  32'(dmi.dmi_req_addr),  32'(m_addr));
        chk($sformatf("rnd%0d.wdata", c), 32'(dmi.dmi_req_wdata), 32'(m_wdata));
      end
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
